// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width/sign encodings and LSU FSM states.
`timescale 1ns / 1ps

package riscv_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

  // Encodings with no RV32I load/store meaning; such requests are dropped.
  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension. Purely combinational.
`timescale 1ns / 1ps

module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the fetched word.
  always_comb begin
    byte_sel = word[7:0];
    unique case (addr)
      2'b00: byte_sel = word[7:0];
      2'b01: byte_sel = word[15:8];
      2'b10: byte_sel = word[23:16];
      2'b11: byte_sel = word[31:24];
    endcase
    // addr[0] is ignored: misaligned halfwords are either trapped upstream or forced down.
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the access width and signedness.
  always_comb begin
    rdata = '0;
    case (funct3)
      F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata = word;
      F3_LBU:  rdata = {24'b0, byte_sel};
      F3_LHU:  rdata = {16'b0, half_sel};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// MEM-stage load/store unit in front of a word-only data memory. Sub-word stores become a
// read-modify-write pair (stall one cycle, then write the merged word); loads are extended
// with zero latency. Optional macro LSU_MISALIGN_TRAP_EN adds the misaligned port and
// suppresses misaligned halfword/word accesses.
`timescale 1ns / 1ps

module lsu_rmw
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic        dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  input  logic [31:0] dmem_rd
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] merge_q, merge_d;

  logic [31:0] word_addr;
  logic [31:0] ext_rdata;
  logic [31:0] merged;
  logic        req_ok;
  logic        trap;

  assign word_addr = {addr[31:2], 2'b00};

  // Reset masks the request so nothing is issued or stalled while it is held.
  assign req_ok = mem_req & ~reset & ~f3_reserved(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword encodings end in 01, word encodings in 10 (for both loads and stores).
  assign trap = req_ok &
                (((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
  assign misaligned = trap & (state_q == IDLE);
`else
  assign trap = 1'b0;
`endif

  lsu_load_ext u_load_ext (
    .word   (dmem_rd),
    .funct3 (funct3),
    .addr   (addr[1:0]),
    .rdata  (ext_rdata)
  );

  // Overlay the store lane(s) on the word just read from memory.
  always_comb begin
    merged = dmem_rd;
    if (funct3 == F3_SB) begin
      unique case (addr[1:0])
        2'b00: merged[7:0]   = wdata[7:0];
        2'b01: merged[15:8]  = wdata[7:0];
        2'b10: merged[23:16] = wdata[7:0];
        2'b11: merged[31:24] = wdata[7:0];
      endcase
    end else if (addr[1]) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end
  end

  // Next state, RMW capture and all memory/pipeline outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    merge_d = merge_q;
    stall   = 1'b0;
    dmem_we = 1'b0;
    dmem_a  = '0;
    dmem_wd = '0;
    rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (req_ok && !trap) begin
          dmem_a = word_addr;
          if (!mem_we) begin
            rdata = ext_rdata;
          end else if (funct3 == F3_SW) begin
            dmem_we = 1'b1;
            dmem_wd = wdata;
          end else if ((funct3 == F3_SB) || (funct3 == F3_SH)) begin
            stall   = 1'b1;
            addr_d  = word_addr;
            merge_d = merged;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Pipeline inputs are ignored here; the held store is committed from the registers.
        dmem_we = 1'b1;
        dmem_a  = addr_q;
        dmem_wd = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and RMW registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: a byte-array memory model predicts every cycle's outputs,
// a monitor pops and compares them on the falling edge.
`timescale 1ns / 1ps

module tb_lsu_rmw;
  import riscv_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mem_req, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, dmem_we;
  logic [31:0] dmem_a, dmem_wd, dmem_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  lsu_rmw dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .dmem_we    (dmem_we),
    .dmem_a     (dmem_a),
    .dmem_wd    (dmem_wd),
    .dmem_rd    (dmem_rd)
  );

  // Word-wide data memory: combinational read, write on rising edge.
  logic [31:0] mem [16];
  assign dmem_rd = mem[dmem_a[5:2]];
  always @(posedge clk) if (dmem_we) mem[dmem_a[5:2]] <= dmem_wd;

  typedef struct {
    int          id;
    bit          stall;
    bit          we;
    bit          chk_a;
    logic [31:0] a;
    bit          chk_wd;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] rd;
    bit          mis;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         op_id = 0;
  logic [7:0] rb [64];

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic logic [31:0] rword(input int aw);
    return {rb[aw+3], rb[aw+2], rb[aw+1], rb[aw]};
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input int a);
    bit raw;
    raw = ((f3[1:0] == 2'b01) && (a % 2 != 0)) || ((f3[1:0] == 2'b10) && (a % 4 != 0));
    return Trap && raw;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    logic [15:0] h;
    h = {rb[(a & ~1) + 1], rb[a & ~1]};
    case (f3)
      F3_LB:   return {{24{rb[a][7]}}, rb[a]};
      F3_LBU:  return {24'b0, rb[a]};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      default: return rword(a & ~3);
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
    case (f3)
      F3_SB: rb[a] = wd[7:0];
      F3_SH: begin
        rb[a & ~1]       = wd[7:0];
        rb[(a & ~1) + 1] = wd[15:8];
      end
      default: for (int i = 0; i < 4; i++) rb[(a & ~3) + i] = wd[8*i +: 8];
    endcase
  endtask

  function automatic exp_t mk(input bit st, input bit we);
    exp_t e;
    e.id = op_id; e.stall = st; e.we = we;
    e.chk_a = 1'b0; e.a = '0; e.chk_wd = 1'b0; e.wd = '0;
    e.chk_rd = 1'b0; e.rd = '0; e.mis = 1'b0;
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic req, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset = rst; mem_req = req; mem_we = we; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic do_idle();
    exp_t e;
    op_id++;
    step(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    e = mk(1'b0, 1'b0);
    e.chk_a = 1'b1; e.chk_wd = 1'b1; e.chk_rd = 1'b1;
    q.push_back(e);
  endtask

  task automatic do_reserved(input logic [2:0] f3, input int a);
    exp_t e;
    op_id++;
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), f3, 32'(a), $urandom);
    e = mk(1'b0, 1'b0);
    e.chk_a = 1'b1; e.chk_wd = 1'b1; e.chk_rd = 1'b1;
    q.push_back(e);
  endtask

  task automatic do_load(input logic [2:0] f3, input int a, input bit use_lit,
                         input logic [31:0] lit);
    exp_t e;
    op_id++;
    step(1'b0, 1'b1, 1'b0, f3, 32'(a), $urandom);
    e = mk(1'b0, 1'b0);
    e.chk_rd = 1'b1;
    if (is_mis(f3, a)) begin
      e.mis = 1'b1;
    end else begin
      e.chk_a = 1'b1;
      e.a     = 32'(a & ~3);
      e.rd    = use_lit ? lit : ref_load(f3, a);
    end
    q.push_back(e);
  endtask

  task automatic do_store(input logic [2:0] f3, input int a, input logic [31:0] wd,
                          input bit abort);
    exp_t e;
    op_id++;
    step(1'b0, 1'b1, 1'b1, f3, 32'(a), wd);
    if (is_mis(f3, a)) begin
      e = mk(1'b0, 1'b0);
      e.mis = 1'b1;
      q.push_back(e);
    end else if (f3 == F3_SW) begin
      ref_store(f3, a, wd);
      e = mk(1'b0, 1'b1);
      e.chk_a = 1'b1; e.a = 32'(a & ~3);
      e.chk_wd = 1'b1; e.wd = rword(a & ~3);
      q.push_back(e);
    end else begin
      e = mk(1'b1, 1'b0);
      e.chk_a = 1'b1; e.a = 32'(a & ~3);
      q.push_back(e);
      // Same store stays on the inputs while the write is committed.
      step(abort, 1'b1, 1'b1, f3, 32'(a), wd);
      if (abort) begin
        e = mk(1'b0, 1'b0);
        e.chk_rd = 1'b1;
        q.push_back(e);
      end else begin
        ref_store(f3, a, wd);
        e = mk(1'b0, 1'b1);
        e.chk_a = 1'b1; e.a = 32'(a & ~3);
        e.chk_wd = 1'b1; e.wd = rword(a & ~3);
        q.push_back(e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s op=%0d got=%h want=%h", nm, id, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", e.id, {31'b0, stall}, {31'b0, e.stall});
        chk("dmem_we", e.id, {31'b0, dmem_we}, {31'b0, e.we});
        if (e.chk_a)  chk("dmem_a", e.id, dmem_a, e.a);
        if (e.chk_wd) chk("dmem_wd", e.id, dmem_wd, e.wd);
        if (e.chk_rd) chk("rdata", e.id, rdata, e.rd);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misaligned", e.id, {31'b0, misaligned}, {31'b0, e.mis});
`endif
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] rs_f3 [3];
    exp_t       e;
    int         kind;
    ld_f3[0] = F3_LB; ld_f3[1] = F3_LH; ld_f3[2] = F3_LW; ld_f3[3] = F3_LBU; ld_f3[4] = F3_LHU;
    rs_f3[0] = 3'b011; rs_f3[1] = 3'b110; rs_f3[2] = 3'b111;
    for (int i = 0; i < 64; i++) rb[i] = 8'h00;

    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;

    // Reset held two cycles with an SB presented: nothing may stall or write.
    for (int i = 0; i < 2; i++) begin
      op_id++;
      step(1'b1, 1'b1, 1'b1, F3_SB, 32'h2, 32'h55);
      e = mk(1'b0, 1'b0);
      e.chk_rd = 1'b1;
      q.push_back(e);
    end
    do_idle();

    // Fill memory with known content.
    for (int i = 0; i < 16; i++) do_store(F3_SW, i * 4, $urandom, 1'b0);

    // SW then LW; SB merge then LW.
    do_store(F3_SW, 0, 32'hDEADBEEF, 1'b0);
    do_load(F3_LW, 0, 1'b1, 32'hDEADBEEF);
    do_store(F3_SB, 2, 32'h00000012, 1'b0);
    do_load(F3_LW, 0, 1'b1, 32'hDE12BEEF);

    // Load extension.
    do_store(F3_SW, 4, 32'h80FF7F01, 1'b0);
    do_load(F3_LB, 6, 1'b1, 32'hFFFFFFFF);
    do_load(F3_LBU, 7, 1'b1, 32'h00000080);
    do_load(F3_LH, 6, 1'b1, 32'hFFFF80FF);
    do_load(F3_LHU, 4, 1'b1, 32'h00007F01);

    // SH aborted by reset in its write cycle, then the word must be unchanged.
    do_store(F3_SH, 8, 32'h0000BEEF, 1'b1);
    do_idle();
    do_load(F3_LW, 8, 1'b0, 32'h0);

    // Back-to-back SBs into one word, each sees the previous merge.
    do_store(F3_SB, 16, 32'hA1, 1'b0);
    do_store(F3_SB, 17, 32'hB2, 1'b0);
    do_store(F3_SH, 18, 32'hC3D4, 1'b0);
    do_load(F3_LW, 16, 1'b0, 32'h0);

    // Misaligned SW: trapped or aligned-down depending on build.
    do_store(F3_SW, 5, 32'hCAFEBABE, 1'b0);
    do_load(F3_LW, 4, 1'b0, 32'h0);
    do_load(F3_LH, 3, 1'b0, 32'h0);

    // Reserved encodings behave like no request.
    for (int i = 0; i < 3; i++) do_reserved(rs_f3[i], 12);

    // Randomised mix.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)       do_load(ld_f3[$urandom_range(0, 4)], $urandom_range(0, 63), 1'b0, 32'h0);
      else if (kind < 8)  do_store(3'($urandom_range(0, 2)), $urandom_range(0, 63), $urandom,
                                   1'b0);
      else if (kind == 8) do_reserved(rs_f3[$urandom_range(0, 2)], $urandom_range(0, 63));
      else                do_idle();
    end

    @(posedge clk);
    #1;
    mem_req = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
